// File: rtl/mem_data_arbiter.sv
// Shares the single-port data memory between the processor and a host port.
// Round-robin arbitration with a bounded host lock for burst transfers.
module mem_data_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_wr,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              h_req,
    input  logic              h_wr,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    typedef enum logic {
        ARB   = 1'b0,
        HLOCK = 1'b1
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       p_rvalid_q, p_rvalid_d;
    logic       h_rvalid_q, h_rvalid_d;

    logic p_gnt_c, h_gnt_c;
    logic lock_hold, arb_last, p_win, h_win;

    // Grant decision and next-state for the arbitration registers.
    always_comb begin
        p_gnt_c     = 1'b0;
        h_gnt_c     = 1'b0;
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        lock_hold   = (state_q == HLOCK) && h_req && h_lock;
        arb_last    = (state_q == HLOCK) ? 1'b1 : last_q;
        p_win       = 1'b0;
        h_win       = 1'b0;
        if (rst) begin
            state_d     = ARB;
            last_d      = 1'b1;
            burst_cnt_d = 4'd0;
        end else if (lock_hold) begin
            if ((burst_cnt_q < MAX_B) || !p_req) begin
                h_gnt_c = 1'b1;
                last_d  = 1'b1;
                if (burst_cnt_q != 4'hF) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end else begin
                // Burst budget spent: yield exactly one slot to the processor.
                p_gnt_c     = 1'b1;
                last_d      = 1'b0;
                state_d     = ARB;
                burst_cnt_d = 4'd0;
            end
        end else begin
            // Leaving the lock behaves as if the host was served last.
            p_win       = p_req && (!h_req || arb_last);
            h_win       = h_req && !p_win;
            state_d     = ARB;
            burst_cnt_d = 4'd0;
            unique case (1'b1)
                p_win: begin
                    p_gnt_c = 1'b1;
                    last_d  = 1'b0;
                end
                h_win: begin
                    h_gnt_c = 1'b1;
                    last_d  = 1'b1;
                    if (h_lock) begin
                        state_d     = HLOCK;
                        burst_cnt_d = 4'd1;
                    end
                end
                default: ;
            endcase
        end
        p_rvalid_d = p_gnt_c & ~p_wr;
        h_rvalid_d = h_gnt_c & ~h_wr;
    end

    // Arbitration state and read-valid pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            last_q      <= 1'b1;
            burst_cnt_q <= 4'd0;
            p_rvalid_q  <= 1'b0;
            h_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            p_rvalid_q  <= p_rvalid_d;
            h_rvalid_q  <= h_rvalid_d;
        end
    end

    // Steer the winner onto the memory port; idle parks on the processor address.
    always_comb begin
        mem_wr       = 1'b0;
        mem_addr     = p_addr;
        mem_data_out = '0;
        if (h_gnt_c) begin
            mem_wr       = h_wr;
            mem_addr     = h_addr;
            mem_data_out = h_wdata;
        end else if (p_gnt_c) begin
            mem_wr       = p_wr;
            mem_addr     = p_addr;
            mem_data_out = p_wdata;
        end
    end

    assign p_gnt    = p_gnt_c;
    assign h_gnt    = h_gnt_c;
    assign p_rvalid = p_rvalid_q;
    assign h_rvalid = h_rvalid_q;
    assign p_rdata  = mem_data_in;
    assign h_rdata  = mem_data_in;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a behavioural
// synchronous-read memory behind the shared port.
module tb_mem_data_arbiter;

    logic        clk;
    logic        rst;
    logic        p_req, p_wr, h_req, h_wr, h_lock;
    logic [7:0]  p_addr, h_addr;
    logic [31:0] p_wdata, h_wdata;
    logic        p_gnt, p_rvalid, h_gnt, h_rvalid;
    logic [31:0] p_rdata, h_rdata;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data_out, mem_data_in;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    mem_data_arbiter #(
        .ADDR_W(8),
        .DATA_W(32),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .p_req(p_req),
        .p_wr(p_wr),
        .p_addr(p_addr),
        .p_wdata(p_wdata),
        .p_gnt(p_gnt),
        .p_rvalid(p_rvalid),
        .p_rdata(p_rdata),
        .h_req(h_req),
        .h_wr(h_wr),
        .h_addr(h_addr),
        .h_wdata(h_wdata),
        .h_lock(h_lock),
        .h_gnt(h_gnt),
        .h_rvalid(h_rvalid),
        .h_rdata(h_rdata),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_data_out;
        mem_data_in <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic gnt(input string tag, input logic ep, input logic eh);
        chk({tag, "_p_gnt"}, {31'd0, p_gnt}, {31'd0, ep});
        chk({tag, "_h_gnt"}, {31'd0, h_gnt}, {31'd0, eh});
    endtask

    initial begin
        rst = 1'b1;
        p_req = 1'b1; p_wr = 1'b0; p_addr = 8'h00; p_wdata = '0;
        h_req = 1'b1; h_wr = 1'b0; h_addr = 8'h00; h_wdata = '0;
        h_lock = 1'b0;

        // reset with both requests held
        @(negedge clk); #1;
        gnt("rst0", 1'b0, 1'b0);
        @(negedge clk); #1;
        gnt("rst1", 1'b0, 1'b0);
        chk("rst_p_rvalid", {31'd0, p_rvalid}, 32'd0);
        chk("rst_h_rvalid", {31'd0, h_rvalid}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);

        // round-robin after reset: processor first
        @(negedge clk); rst = 1'b0; #1;
        gnt("rr0", 1'b1, 1'b0);
        @(negedge clk); #1;
        gnt("rr1", 1'b0, 1'b1);
        @(negedge clk); #1;
        gnt("rr2", 1'b1, 1'b0);
        @(negedge clk); #1;
        gnt("rr3", 1'b0, 1'b1);

        // host write then processor read of the same word
        @(negedge clk);
        p_req = 1'b0;
        h_wr = 1'b1; h_addr = 8'h10; h_wdata = 32'hDEADBEEF;
        #1;
        gnt("hw", 1'b0, 1'b1);
        chk("hw_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("hw_mem_addr", {24'd0, mem_addr}, 32'h10);
        chk("hw_mem_data", mem_data_out, 32'hDEADBEEF);
        @(negedge clk);
        h_req = 1'b0; h_wr = 1'b0;
        p_req = 1'b1; p_wr = 1'b0; p_addr = 8'h10;
        #1;
        gnt("pr", 1'b1, 1'b0);
        chk("pr_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("hw_no_rvalid", {31'd0, h_rvalid}, 32'd0);
        @(negedge clk);
        p_req = 1'b0;
        #1;
        chk("pr_rvalid", {31'd0, p_rvalid}, 32'd1);
        chk("pr_rdata", p_rdata, 32'hDEADBEEF);
        chk("pr_h_rvalid", {31'd0, h_rvalid}, 32'd0);
        chk("idle_addr", {24'd0, mem_addr}, 32'h10);
        chk("idle_data", mem_data_out, 32'd0);
        gnt("idle", 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("pr_rvalid_1shot", {31'd0, p_rvalid}, 32'd0);

        // bounded host lock with processor waiting
        @(negedge clk);
        p_req = 1'b1; h_req = 1'b1; h_lock = 1'b1;
        #1;
        gnt("lk0", 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #1;
            gnt($sformatf("lk%0d", i), 1'b0, 1'b1);
        end
        @(negedge clk); #1;
        gnt("lk_yield", 1'b1, 1'b0);
        @(negedge clk); h_lock = 1'b0; #1;
        gnt("lk_rr0", 1'b0, 1'b1);
        @(negedge clk); #1;
        gnt("lk_rr1", 1'b1, 1'b0);

        // host lock with no processor demand: no forced yield
        @(negedge clk);
        p_req = 1'b0; h_lock = 1'b1;
        #1;
        gnt("free0", 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk); #1;
            gnt($sformatf("free%0d", i), 1'b0, 1'b1);
        end
        @(negedge clk); p_req = 1'b1; #1;
        gnt("free_yield", 1'b1, 1'b0);

        // lock dropped after two grants
        @(negedge clk); #1;
        gnt("drop0", 1'b0, 1'b1);
        @(negedge clk); #1;
        gnt("drop1", 1'b0, 1'b1);
        @(negedge clk); h_lock = 1'b0; #1;
        gnt("drop_exit", 1'b1, 1'b0);
        @(negedge clk); #1;
        gnt("drop_rr0", 1'b0, 1'b1);
        @(negedge clk); h_lock = 1'b1; #1;
        gnt("drop_arb", 1'b1, 1'b0);

        // reset right after a processor read grant
        @(negedge clk);
        h_req = 1'b0; h_lock = 1'b0;
        p_req = 1'b1; p_wr = 1'b0; p_addr = 8'h10;
        #1;
        gnt("rr_rd", 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; h_req = 1'b1; h_lock = 1'b1;
        #1;
        gnt("mid_rst0", 1'b0, 1'b0);
        chk("mid_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(negedge clk); #1;
        chk("mid_rst_rvalid", {31'd0, p_rvalid}, 32'd0);
        chk("mid_rst_hrvalid", {31'd0, h_rvalid}, 32'd0);
        gnt("mid_rst1", 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        gnt("post_rst0", 1'b1, 1'b0);
        @(negedge clk); #1;
        gnt("post_rst1", 1'b0, 1'b1);
        chk("post_rst_rvalid", {31'd0, p_rvalid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
